pcie_rx_vc_demux: RTL
=====================

// Module: pcie_rx_vc_demux
// PURPOSE
//  Receive-side counterpart of the two-lane PCIe VC transmitter. Takes two 6-bit lanes (bit5 = VC id,
//  [4:0] = payload), demuxes each word into one of four per-VC/per-lane buffers (VC0P0,VC1P0,VC0P1,VC1P1)
//  and drains them to the consumer via per-buffer read strobes. Generates pause/continue flow-control
//  toward the link partner from buffer fill vs latched thresholds. Runs an init/idle/active/error control FSM.
// PARAMETERS
//  DATA_W   5   payload width (lane word = DATA_W+1 bits)
//  DEPTH    8   entries per VC buffer (power of two)
//  ADDR_W   3   log2(DEPTH); fill counters are ADDR_W+1 bits
// PORTS
//  clk            in   1        clock, all logic on rising edge
//  reset          in   1        synchronous, active-high
//  init           in   1        enter/stay in INIT; thresholds latched while high
//  umbral_hi      in   4        pause threshold (fill >= hi -> pause)
//  umbral_lo      in   4        continue threshold (fill <= lo -> continue)
//  valid_p0/p1    in   1        lane word valid
//  data_p0/p1     in   6        lane word: [5]=VC, [4:0]=payload
//  rd_en          in   4        pop strobe per buffer, index 0=VC0P0 1=VC1P0 2=VC0P1 3=VC1P1
//  rd_data        out  4*5      {b3,b2,b1,b0} popped payloads, registered
//  rd_valid       out  4        per buffer: rd_data slice valid this cycle (1-cycle pulse)
//  empty          out  4        per buffer fill == 0
//  pause          out  4        per buffer fill >= hi_lat
//  continue_o     out  4        per buffer fill <= lo_lat
//  active/idle/error out 1 each one-hot FSM status (INIT: all three 0)
//  rx_cnt_p0/p1   out  8        accepted-word counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FSM=INIT; all fills, pointers, rd_data, rd_valid, counters = 0; empty=4'hF; pause=0;
//   continue_o=4'hF; hi_lat=DEPTH, lo_lat=0.
//  Input stage: lane words registered once (valid and data); buffer index = {lane, data[5]}.
//   Write into buffer on next edge => word at edge N visible as empty=0 after edge N+1.
//  Read: rd_en[i] sampled at edge M with buffer i non-empty -> rd_data slice + rd_valid[i]=1 after edge M;
//   min lane-to-rd_data latency 3 edges. rd_data holds last value when rd_valid=0.
//  Both lanes may write the same cycle (always distinct buffers). All 4 buffers pop independently.
//  Simultaneous push+pop on one buffer: both happen, fill unchanged, legal even when full or empty
//   (pop+push on empty: pop is an underflow, push still taken).
//  Overflow: push to full buffer -> word dropped, FSM->ERROR. Underflow: rd_en on empty -> no rd_valid,
//   FSM->ERROR. Pointers wrap modulo DEPTH.
//  FSM: INIT: buffers flushed every cycle, lane words dropped, hi_lat<=min(umbral_hi,DEPTH),
//   lo_lat<=umbral_lo; init=0 -> IDLE. IDLE: all empty; any accepted write -> ACTIVE.
//   ACTIVE: all buffers empty and no write in input stage -> IDLE. ERROR: sticky, writes dropped,
//   reads still served; leaves only via init=1 (->INIT) or reset. init=1 from any state -> INIT next edge
//   (mid-traffic: buffered data discarded). Error detection has priority over IDLE/ACTIVE moves.
//  pause/continue_o/empty decoded from registered fill (reflect fill after each edge). If lo_lat>=hi_lat
//   both may assert together; no arbitration implied.
// CONFIGURATION
//  RX_CNT_EN defined: rx_cnt_p0/p1 count words written into lane-0/lane-1 buffers, 8-bit saturating at 255,
//   cleared by reset and in INIT; dropped words not counted.
//  RX_CNT_EN undefined: counters not built, rx_cnt_p0/p1 tied to 0.
// TESTING
//  reset, init=1 hi=6 lo=2, init=0 -> INIT then IDLE; empty=F, continue_o=F, pause=0, idle=1.
//  valid_p0, data_p0=6'h25 -> 3 edges later empty[1]=0; rd_en[1] -> rd_data[9:5]=5'h05, rd_valid[1]=1.
//  6 words to VC0P1 with no pops -> pause[2]=1 at fill 6, continue_o[2]=0 at fill 3; pop to 2 -> continue_o[2]=1.
//  9 words to VC0P0, DEPTH=8 -> 9th dropped, error=1 sticky; init pulse -> INIT, buffers empty, idle after.
//  rd_en[3] on empty -> rd_valid[3]=0, error=1; same-cycle push+pop on full buffer -> fill stays 8, no error.
//  RX_CNT_EN: 300 lane-1 words with pops -> rx_cnt_p1=255; undefined -> rx_cnt_p1=0.

Source files
------------

// File: rtl/pcie_rx_vc_demux.sv
// pcie_rx_vc_demux: two-lane PCIe RX demux into four per-VC/per-lane buffers with pause/continue flow control.
// Optional macro RX_CNT_EN builds the saturating per-lane accepted-word counters (tied to 0 otherwise).

module pcie_rx_vc_demux #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic [3:0]          umbral_hi,
    input  logic [3:0]          umbral_lo,
    input  logic                valid_p0,
    input  logic                valid_p1,
    input  logic [DATA_W:0]     data_p0,
    input  logic [DATA_W:0]     data_p1,
    input  logic [3:0]          rd_en,
    output logic [4*DATA_W-1:0] rd_data,
    output logic [3:0]          rd_valid,
    output logic [3:0]          empty,
    output logic [3:0]          pause,
    output logic [3:0]          continue_o,
    output logic                active,
    output logic                idle,
    output logic                error,
    output logic [7:0]          rx_cnt_p0,
    output logic [7:0]          rx_cnt_p1
);

    localparam int FW = ADDR_W + 1;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR} state_t;
    state_t state, state_nx;

    logic [1:0]      lane_valid;
    logic [DATA_W:0] lane_data0;
    logic [DATA_W:0] lane_data1;
    logic [FW-1:0]   hi_lat;
    logic [3:0]      lo_lat;
    logic            flush;
    logic            accepting;
    logic            serving;
    logic [3:0]      push_req;
    logic [3:0]      push_ok;
    logic [3:0]      pop_ok;
    logic [3:0]      overflow;
    logic [3:0]      underflow;

    // init is honoured on the edge it is sampled, so INIT is entered with clean buffers
    assign flush     = init || (state == ST_INIT);
    assign accepting = !init && ((state == ST_IDLE) || (state == ST_ACTIVE));
    assign serving   = !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_valid <= '0;
            lane_data0 <= '0;
            lane_data1 <= '0;
        end else begin
            lane_valid <= flush ? 2'b00 : {valid_p1, valid_p0};
            lane_data0 <= data_p0;
            lane_data1 <= data_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_lat <= FW'(DEPTH);
            lo_lat <= '0;
        end else if (flush) begin
            hi_lat <= (int'(umbral_hi) > DEPTH) ? FW'(DEPTH) : FW'(umbral_hi);
            lo_lat <= umbral_lo;
        end
    end

    // buffer index is {lane, vc}
    assign push_req[0] = accepting && lane_valid[0] && !lane_data0[DATA_W];
    assign push_req[1] = accepting && lane_valid[0] &&  lane_data0[DATA_W];
    assign push_req[2] = accepting && lane_valid[1] && !lane_data1[DATA_W];
    assign push_req[3] = accepting && lane_valid[1] &&  lane_data1[DATA_W];

    for (genvar b = 0; b < 4; b++) begin : g_buf
        logic [DATA_W-1:0] mem [DEPTH];
        logic [ADDR_W-1:0] wr_ptr;
        logic [ADDR_W-1:0] rd_ptr;
        logic [FW-1:0]     fill;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rd_q;
        logic              rv_q;

        assign wdata = (b < 2) ? lane_data0[DATA_W-1:0] : lane_data1[DATA_W-1:0];

        // a pop in the same cycle frees the slot, so push into a full buffer is still legal
        assign pop_ok[b]    = serving && rd_en[b] && (fill != '0);
        assign underflow[b] = serving && rd_en[b] && (fill == '0);
        assign push_ok[b]   = push_req[b] && ((fill != FW'(DEPTH)) || pop_ok[b]);
        assign overflow[b]  = push_req[b] && !push_ok[b];

        assign empty[b]      = (fill == '0);
        assign pause[b]      = (fill >= hi_lat);
        assign continue_o[b] = (32'(fill) <= 32'(lo_lat));

        always_ff @(posedge clk) begin
            if (push_ok[b])
                mem[wr_ptr] <= wdata;
        end

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                fill   <= '0;
            end else begin
                if (push_ok[b])
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                if (pop_ok[b])
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                fill <= fill + FW'(push_ok[b]) - FW'(pop_ok[b]);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_q <= '0;
                rv_q <= 1'b0;
            end else begin
                rv_q <= pop_ok[b];
                if (pop_ok[b])
                    rd_q <= mem[rd_ptr];
            end
        end

        assign rd_data[b*DATA_W +: DATA_W] = rd_q;
        assign rd_valid[b]                 = rv_q;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_INIT;
        else
            state <= state_nx;
    end

    // errors win over the idle/active bookkeeping; ERROR only leaves through init
    always_comb begin
        state_nx = state;
        if (init) begin
            state_nx = ST_INIT;
        end else begin
            case (state)
                ST_INIT:   state_nx = ST_IDLE;
                ST_IDLE: begin
                    if ((|overflow) || (|underflow))
                        state_nx = ST_ERROR;
                    else if (|push_ok)
                        state_nx = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if ((|overflow) || (|underflow))
                        state_nx = ST_ERROR;
                    else if ((&empty) && (lane_valid == 2'b00))
                        state_nx = ST_IDLE;
                end
                ST_ERROR:  state_nx = ST_ERROR;
                default:   state_nx = ST_INIT;
            endcase
        end
    end

    assign active = (state == ST_ACTIVE);
    assign idle   = (state == ST_IDLE);
    assign error  = (state == ST_ERROR);

`ifdef RX_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rx_cnt_p0 <= '0;
            rx_cnt_p1 <= '0;
        end else begin
            if ((push_ok[0] || push_ok[1]) && (rx_cnt_p0 != 8'hFF))
                rx_cnt_p0 <= rx_cnt_p0 + 8'd1;
            if ((push_ok[2] || push_ok[3]) && (rx_cnt_p1 != 8'hFF))
                rx_cnt_p1 <= rx_cnt_p1 + 8'd1;
        end
    end
`else
    assign rx_cnt_p0 = '0;
    assign rx_cnt_p1 = '0;
`endif

endmodule
